// File: rtl/mod_cnt_monitor.sv
// Receive-side checker for a modulo-MOD count stream: locks onto the sequence, then counts wraps and breaks.
// Build option: define MOD_MON_STICKY_EN to latch the first break in LOCKED into a FAIL state held until rst.
//
// state   | meaning
// --------+-----------------------------------------------------------
// EMPTY   | no usable seed yet; waiting for a legal valid sample
// HUNT    | seeded; counting consecutive correct steps toward lock
// LOCKED  | sequence tracked; wraps counted, mismatches flagged
// FAIL    | (sticky build only) first break latched; frozen until rst
module mod_cnt_monitor #(
    parameter int MOD    = 18,
    parameter int WIDTH  = 5,
    parameter int LOCK_N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_vld,
    output logic             locked,
    output logic             wrap_pulse,
    output logic             err_pulse,
    output logic [15:0]      wrap_count,
    output logic [7:0]       err_count,
    output logic [WIDTH-1:0] expected
);

    localparam int MC_W = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_HUNT   = 2'd1,
        S_LOCKED = 2'd2
`ifdef MOD_MON_STICKY_EN
        , S_FAIL = 2'd3
`endif
    } state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] exp_nxt;
    logic [MC_W-1:0]  match_cnt, mc_nxt;
    logic             wrap_ev, err_ev;
    logic             legal, hit;
    logic [WIDTH-1:0] succ;

    // One extra bit so MOD == 2**WIDTH still compares correctly.
    assign legal = ({1'b0, cnt_in} < (WIDTH+1)'(MOD));
    assign hit   = legal && (cnt_in == expected);
    assign succ  = (cnt_in == WIDTH'(MOD-1)) ? '0 : cnt_in + 1'b1;

    always_comb begin
        state_nxt = state;
        exp_nxt   = expected;
        mc_nxt    = match_cnt;
        wrap_ev   = 1'b0;
        err_ev    = 1'b0;
        if (cnt_vld) begin
            case (state)
                S_EMPTY: begin
                    if (legal) begin
                        exp_nxt   = succ;
                        mc_nxt    = '0;
                        state_nxt = S_HUNT;
                    end
                end
                S_HUNT: begin
                    if (hit) begin
                        exp_nxt = succ;
                        if (match_cnt == MC_W'(LOCK_N-1)) begin
                            state_nxt = S_LOCKED;
                            mc_nxt    = '0;
                        end else begin
                            mc_nxt = match_cnt + 1'b1;
                        end
                    end else if (legal) begin
                        exp_nxt = succ;
                        mc_nxt  = '0;
                    end else begin
                        state_nxt = S_EMPTY;
                        mc_nxt    = '0;
                    end
                end
                S_LOCKED: begin
                    if (hit) begin
                        exp_nxt = succ;
                        // A matched 0 while locked always follows an accepted MOD-1.
                        wrap_ev = (cnt_in == '0);
                    end else begin
                        err_ev = 1'b1;
`ifdef MOD_MON_STICKY_EN
                        state_nxt = S_FAIL;
`else
                        mc_nxt = '0;
                        if (legal) begin
                            state_nxt = S_HUNT;
                            exp_nxt   = succ;
                        end else begin
                            state_nxt = S_EMPTY;
                        end
`endif
                    end
                end
`ifdef MOD_MON_STICKY_EN
                S_FAIL: begin
                    state_nxt = S_FAIL;
                end
`endif
                default: begin
                    state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_EMPTY;
            expected   <= '0;
            match_cnt  <= '0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_count <= '0;
            err_count  <= '0;
        end else begin
            state      <= state_nxt;
            expected   <= exp_nxt;
            match_cnt  <= mc_nxt;
            wrap_pulse <= wrap_ev;
            err_pulse  <= err_ev;
            if (wrap_ev && (wrap_count != 16'hFFFF))
                wrap_count <= wrap_count + 16'd1;
            if (err_ev && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

    assign locked = (state == S_LOCKED);

endmodule

// File: tb/tb_mod_cnt_monitor.sv
// Bench for mod_cnt_monitor: hand-computed vector table, then a randomized stream against a sequence-level model.
module tb_mod_cnt_monitor;

    localparam int MOD    = 18;
    localparam int WIDTH  = 5;
    localparam int LOCK_N = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] cnt_in;
    logic             cnt_vld;
    logic             locked, wrap_pulse, err_pulse;
    logic [15:0]      wrap_count;
    logic [7:0]       err_count;
    logic [WIDTH-1:0] expected;

    int checks   = 0;
    int failures = 0;

    mod_cnt_monitor #(.MOD(MOD), .WIDTH(WIDTH), .LOCK_N(LOCK_N)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_vld(cnt_vld),
        .locked(locked), .wrap_pulse(wrap_pulse), .err_pulse(err_pulse),
        .wrap_count(wrap_count), .err_count(err_count), .expected(expected)
    );

    always #5 clk = ~clk;

    // Reference model: tracks run length and last accepted value of the stream.
    bit m_seeded, m_locked, m_failed, m_wp, m_ep;
    int m_run, m_last, m_exp, m_wc, m_ec;

    task automatic m_seed(input int c);
        m_seeded = 1; m_run = 1; m_last = c; m_exp = (c + 1) % MOD;
    endtask

    task automatic model_step(input bit r, input bit v, input int c);
        m_wp = 0; m_ep = 0;
        if (r) begin
            m_seeded = 0; m_locked = 0; m_failed = 0;
            m_run = 0; m_last = 0; m_exp = 0; m_wc = 0; m_ec = 0;
        end else if (v && !m_failed) begin
            if (m_locked) begin
                if (c == m_exp) begin
                    if (m_last == MOD-1 && c == 0) begin
                        m_wp = 1;
                        if (m_wc < 65535) m_wc++;
                    end
                    m_last = c; m_exp = (c + 1) % MOD;
                end else begin
                    m_ep = 1;
                    if (m_ec < 255) m_ec++;
                    m_locked = 0;
`ifdef MOD_MON_STICKY_EN
                    m_failed = 1;
`else
                    if (c < MOD) m_seed(c);
                    else m_seeded = 0;
`endif
                end
            end else if (m_seeded) begin
                if (c == m_exp) begin
                    m_run++; m_last = c; m_exp = (c + 1) % MOD;
                    if (m_run == LOCK_N + 1) m_locked = 1;
                end else if (c < MOD) begin
                    m_seed(c);
                end else begin
                    m_seeded = 0;
                end
            end else if (c < MOD) begin
                m_seed(c);
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input int c);
        @(negedge clk);
        rst = r; cnt_vld = v; cnt_in = WIDTH'(c);
        @(posedge clk);
        model_step(r, v, c);
        #1;
    endtask

    task automatic chk_all(input string tag, input int lk, input int wp, input int ep,
                           input int ex, input int wc, input int ec);
        chk({tag, ".locked"},     int'(locked),     lk);
        chk({tag, ".wrap_pulse"}, int'(wrap_pulse), wp);
        chk({tag, ".err_pulse"},  int'(err_pulse),  ep);
        chk({tag, ".expected"},   int'(expected),   ex);
        chk({tag, ".wrap_count"}, int'(wrap_count), wc);
        chk({tag, ".err_count"},  int'(err_count),  ec);
    endtask

    typedef struct {
        bit r; bit v; int c;
        int lk; int wp; int ep; int ex; int wc; int ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit v, int c, int lk, int wp, int ep, int ex, int wc, int ec);
        vec_t t;
        t.r = r; t.v = v; t.c = c; t.lk = lk; t.wp = wp; t.ep = ep; t.ex = ex; t.wc = wc; t.ec = ec;
        return t;
    endfunction

    initial begin
        rst = 1'b1; cnt_vld = 1'b0; cnt_in = '0;

`ifndef MOD_MON_STICKY_EN
        //               r  v  c   lk wp ep ex wc ec
        tbl.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1,  0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(0, 1, 2,  0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 1, 3,  1, 0, 0, 4, 0, 0));
        tbl.push_back(mk(0, 1, 4,  1, 0, 0, 5, 0, 0));
        tbl.push_back(mk(0, 0, 9,  1, 0, 0, 5, 0, 0));
        tbl.push_back(mk(0, 0, 30, 1, 0, 0, 5, 0, 0));
        tbl.push_back(mk(0, 1, 5,  1, 0, 0, 6, 0, 0));
        tbl.push_back(mk(0, 1, 6,  1, 0, 0, 7, 0, 0));
        tbl.push_back(mk(0, 1, 7,  1, 0, 0, 8, 0, 0));
        tbl.push_back(mk(0, 1, 8,  1, 0, 0, 9, 0, 0));
        tbl.push_back(mk(0, 1, 12, 0, 0, 1, 13, 0, 1));
        tbl.push_back(mk(0, 1, 13, 0, 0, 0, 14, 0, 1));
        tbl.push_back(mk(0, 1, 14, 0, 0, 0, 15, 0, 1));
        tbl.push_back(mk(0, 1, 15, 1, 0, 0, 16, 0, 1));
        tbl.push_back(mk(0, 1, 16, 1, 0, 0, 17, 0, 1));
        tbl.push_back(mk(0, 1, 17, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0,  1, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1,  1, 0, 0, 2, 1, 1));
        tbl.push_back(mk(0, 1, 20, 0, 0, 1, 2, 1, 2));
        tbl.push_back(mk(0, 1, 5,  0, 0, 0, 6, 1, 2));
        tbl.push_back(mk(1, 1, 6,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1,  0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(0, 1, 2,  0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 1, 3,  1, 0, 0, 4, 0, 0));
`else
        tbl.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1,  0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(0, 1, 2,  0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 1, 3,  1, 0, 0, 4, 0, 0));
        tbl.push_back(mk(0, 1, 4,  1, 0, 0, 5, 0, 0));
        tbl.push_back(mk(0, 1, 9,  0, 0, 1, 5, 0, 1));
        tbl.push_back(mk(0, 1, 7,  0, 0, 0, 5, 0, 1));
        tbl.push_back(mk(0, 1, 5,  0, 0, 0, 5, 0, 1));
        tbl.push_back(mk(0, 1, 6,  0, 0, 0, 5, 0, 1));
        tbl.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1,  0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(0, 1, 2,  0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 1, 3,  1, 0, 0, 4, 0, 0));
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].c);
            chk_all($sformatf("vec%0d", i), tbl[i].lk, tbl[i].wp, tbl[i].ep,
                    tbl[i].ex, tbl[i].wc, tbl[i].ec);
        end

        // Randomized stream: mostly on-sequence values, with gaps, glitches, illegal values, rare resets.
        step(1, 0, 0);
        chk_all("rnd_reset", int'(m_locked), int'(m_wp), int'(m_ep), m_exp, m_wc, m_ec);
        for (int n = 0; n < 4000; n++) begin
            bit r, v;
            int c;
            r = ($urandom_range(599) == 0);
            v = ($urandom_range(3) != 0);
            if ($urandom_range(19) < 17)
                c = (m_seeded || m_locked) ? m_exp : int'($urandom_range(MOD-1));
            else
                c = int'($urandom_range(31));
            step(r, v, c);
            chk_all("rnd", int'(m_locked), int'(m_wp), int'(m_ep), m_exp, m_wc, m_ec);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
